lb_step_sequencer: RTL

- Initiator side of the start/finish handshake exported by collide_stream_fsm.
- Owns the per-frame ordering of the LB engine phases: init, ship init, N × (collide, stream), speed-color, move-trace.
- Sits between the HPS-facing control registers (go, cmd_init, steps_per_frame) and the LB engine, replacing manual start toggling by software or bench.

---
 rtl/lb_step_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lb_step_sequencer.sv
// Frame sequencer for the LB engine: drives the 4-phase start/finish handshake for
// init, ship init, N x (collide, stream), speed-color and move-trace, with a per-state timeout.
module lb_step_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic                   cmd_init,
    input  logic                   clear_err,
    input  logic [7:0]             steps_per_frame,
    input  logic                   init_finish,
    input  logic                   init_ship_finish,
    input  logic                   collide_finish,
    input  logic                   stream_finish,
    input  logic                   speed_color_finish,
    input  logic                   move_trace_finish,
    output logic                   start_init,
    output logic                   init_ship,
    output logic                   start_collide,
    output logic                   start_stream,
    output logic                   start_speed_color,
    output logic                   start_move_trace,
    output logic                   busy,
    output logic                   initialized,
    output logic                   frame_done,
    output logic [7:0]             step_count,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   error,
    output logic [2:0]             error_phase
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FRAME_CNT_W-1:0] FrameOne = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        StIdle, StInitReq, StInitRel, StShipReq, StShipRel, StColReq, StColRel,
        StStrReq, StStrRel, StSpdReq, StSpdRel, StTrcReq, StTrcRel, StFdone, StError
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [7:0]             spf_q, spf_d;
    logic [7:0]             step_count_q, step_count_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   initialized_q, initialized_d;
    logic                   error_q, error_d;
    logic [2:0]             error_phase_q, error_phase_d;
    logic [5:0]             start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    logic       fin;
    logic       in_phase;
    logic [2:0] phase;
    logic [7:0] step_inc;
    logic [7:0] spf_eff;

    assign step_inc = step_count_q + 8'd1;
    assign spf_eff  = (steps_per_frame == 8'd0) ? 8'd1 : steps_per_frame;

    // Phase decode of the current REQ/REL state, used for finish select and error_phase.
    always_comb begin
        phase    = 3'd0;
        in_phase = 1'b1;
        unique case (state_q)
            StInitReq, StInitRel: phase = 3'd0;
            StShipReq, StShipRel: phase = 3'd1;
            StColReq,  StColRel:  phase = 3'd2;
            StStrReq,  StStrRel:  phase = 3'd3;
            StSpdReq,  StSpdRel:  phase = 3'd4;
            StTrcReq,  StTrcRel:  phase = 3'd5;
            default:              in_phase = 1'b0;
        endcase
    end

    always_comb begin
        unique case (phase)
            3'd0:    fin = init_finish;
            3'd1:    fin = init_ship_finish;
            3'd2:    fin = collide_finish;
            3'd3:    fin = stream_finish;
            3'd4:    fin = speed_color_finish;
            default: fin = move_trace_finish;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        spf_d         = spf_q;
        step_count_d  = step_count_q;
        frame_count_d = frame_count_q;
        initialized_d = initialized_q;
        error_d       = error_q;
        error_phase_d = error_phase_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_init || (go && !initialized_q)) begin
                    state_d = StInitReq;
                end else if (go) begin
                    state_d      = StColReq;
                    step_count_d = 8'd0;
                    spf_d        = spf_eff;
                end
            end
            StInitReq: if (fin)  state_d = StInitRel;
            StInitRel: if (!fin) state_d = StShipReq;
            StShipReq: if (fin)  state_d = StShipRel;
            StShipRel: begin
                if (!fin) begin
                    state_d       = StIdle;
                    initialized_d = 1'b1;
                end
            end
            StColReq: if (fin)  state_d = StColRel;
            StColRel: if (!fin) state_d = StStrReq;
            StStrReq: if (fin)  state_d = StStrRel;
            StStrRel: begin
                if (!fin) begin
                    step_count_d = step_inc;
                    state_d      = (step_inc < spf_q) ? StColReq : StSpdReq;
                end
            end
            StSpdReq: if (fin)  state_d = StSpdRel;
            StSpdRel: if (!fin) state_d = StTrcReq;
            StTrcReq: if (fin)  state_d = StTrcRel;
            StTrcRel: if (!fin) state_d = StFdone;
            StFdone: begin
                frame_count_d = frame_count_q + FrameOne;
                // Chain straight into the next frame so collide starts right after frame_done.
                if (go) begin
                    state_d      = StColReq;
                    step_count_d = 8'd0;
                    spf_d        = spf_eff;
                end else begin
                    state_d = StIdle;
                end
            end
            StError: begin
                if (clear_err) begin
                    state_d = StIdle;
                    error_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (in_phase && (timer_q == TLast) && (state_d == state_q)) begin
            state_d       = StError;
            error_d       = 1'b1;
            error_phase_d = phase;
        end
    end

    always_comb begin
        timer_d      = (state_d != state_q) ? '0 : timer_q + TW'(1);
        start_d      = 6'd0;
        busy_d       = (state_d != StIdle) && (state_d != StError);
        frame_done_d = (state_d == StFdone);
        unique case (state_d)
            StInitReq: start_d[0] = 1'b1;
            StShipReq: start_d[1] = 1'b1;
            StColReq:  start_d[2] = 1'b1;
            StStrReq:  start_d[3] = 1'b1;
            StSpdReq:  start_d[4] = 1'b1;
            StTrcReq:  start_d[5] = 1'b1;
            default:   start_d    = 6'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            spf_q         <= 8'd0;
            step_count_q  <= 8'd0;
            frame_count_q <= '0;
            initialized_q <= 1'b0;
            error_q       <= 1'b0;
            error_phase_q <= 3'd0;
            start_q       <= 6'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            spf_q         <= spf_d;
            step_count_q  <= step_count_d;
            frame_count_q <= frame_count_d;
            initialized_q <= initialized_d;
            error_q       <= error_d;
            error_phase_q <= error_phase_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign start_init        = start_q[0];
    assign init_ship         = start_q[1];
    assign start_collide     = start_q[2];
    assign start_stream      = start_q[3];
    assign start_speed_color = start_q[4];
    assign start_move_trace  = start_q[5];
    assign busy              = busy_q;
    assign initialized       = initialized_q;
    assign frame_done        = frame_done_q;
    assign step_count        = step_count_q;
    assign frame_count       = frame_count_q;
    assign error             = error_q;
    assign error_phase       = error_phase_q;

endmodule
